core_mem_arbiter: RTL

CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

---
 rtl/core_mem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/core_mem_arbiter.sv
// Two-requester OBI arbiter sharing one in-order memory port.
// Responses are routed back using a FIFO of requester IDs.
module core_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,

    output logic        protocol_err_o
);

    localparam logic [2:0] MaxCnt  = 3'(MaxOutstanding);
    localparam logic [1:0] LastPtr = 2'(MaxOutstanding - 1);

    logic [2:0] count_q;
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [3:0] id_q;
    logic       rr_q, lock_q, lock_sel_q, perr_q;

    logic       lock_hit, sel_instr, mem_req, handshake, fifo_empty, pop, stray;
    logic [2:0] occupancy;

    function automatic logic [1:0] inc_ptr(input logic [1:0] p);
        return (p == LastPtr) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        // The lock only binds while the locked requester still asks.
        lock_hit   = lock_q & (lock_sel_q ? instr_req_i : data_req_i);
        if (lock_hit) begin
            sel_instr = lock_sel_q;
        end else if (instr_req_i != data_req_i) begin
            sel_instr = instr_req_i;
        end else begin
            sel_instr = rr_q;
        end
        fifo_empty = (count_q == 3'd0);
        pop        = ~rst_i & mem_rvalid_i & ~fifo_empty;
        stray      = mem_rvalid_i & fifo_empty;
        // A response retiring this cycle frees its slot immediately.
        occupancy  = count_q - {2'b00, pop};
        mem_req    = ~rst_i & (instr_req_i | data_req_i) & (occupancy < MaxCnt);
        handshake  = mem_req & mem_gnt_i;
    end

    always_comb begin
        mem_req_o   = mem_req;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (mem_req) begin
            if (sel_instr) begin
                mem_be_o   = 4'hF;
                mem_addr_o = instr_addr_i;
            end else begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end
        end
        instr_gnt_o    = handshake & sel_instr;
        data_gnt_o     = handshake & ~sel_instr;
        instr_rvalid_o = pop & id_q[rd_ptr_q];
        instr_err_o    = pop & id_q[rd_ptr_q] & mem_err_i;
        data_rvalid_o  = pop & ~id_q[rd_ptr_q];
        data_err_o     = pop & ~id_q[rd_ptr_q] & mem_err_i;
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;
        protocol_err_o = perr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q    <= 3'd0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            id_q       <= 4'h0;
            rr_q       <= 1'b0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            if (handshake) begin
                id_q[wr_ptr_q] <= sel_instr;
                wr_ptr_q       <= inc_ptr(wr_ptr_q);
                rr_q           <= ~sel_instr;
                lock_q         <= 1'b0;
            end else if (mem_req) begin
                lock_q     <= 1'b1;
                lock_sel_q <= sel_instr;
            end
            if (pop) begin
                rd_ptr_q <= inc_ptr(rd_ptr_q);
            end
            if (handshake && !pop) begin
                count_q <= count_q + 3'd1;
            end else if (!handshake && pop) begin
                count_q <= count_q - 3'd1;
            end
            if (stray) begin
                perr_q <= 1'b1;
            end
        end
    end

endmodule
